// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pkg
//  Brief    : Shared helpers and control record for the pipelined CLA adder.
//  Revision : 1.0 - initial release
// ============================================================================
package cla_pkg;

    // Control half of a pipeline stage record; the operand and partial-sum
    // fields depend on WIDTH and are added by the top level.
    typedef struct packed {
        logic valid;
        logic carry;
    } cla_ctrl_t;

    // Stage count for a WIDTH-bit operand split into BLOCK-bit groups.
    // A degenerate BLOCK yields 1 so that elaboration reaches the static check.
    function automatic int cla_nstg(input int width, input int block);
        return (block < 1) ? 1 : (width / block);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// ============================================================================
//  Module   : cla_group
//  Brief    : Combinational BLOCK-bit carry-lookahead slice with group G/P.
//  Revision : 1.0 - initial release
// ============================================================================
module cla_group #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c_in,
    output logic [BLOCK-1:0] s,
    output logic             c_out,
    output logic             g,
    output logic             p
);

    logic [BLOCK-1:0] w_gen;
    logic [BLOCK-1:0] w_prop;
    logic [BLOCK:0]   w_c;
    logic             w_grp_g;
    logic             w_grp_p;

    assign w_gen  = a & b;
    assign w_prop = a ^ b;

    // Each carry is a flat sum of products over the lower bits, so no carry
    // depends on another carry inside the slice.
    always_comb begin
        logic w_run;
        logic w_acc;
        w_c     = '0;
        w_c[0]  = c_in;
        w_run   = 1'b1;
        w_acc   = 1'b0;
        w_grp_g = 1'b0;
        w_grp_p = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            w_run = 1'b1;
            w_acc = 1'b0;
            for (int j = i; j >= 0; j--) begin
                w_acc = w_acc | (w_gen[j] & w_run);
                w_run = w_run & w_prop[j];
            end
            w_c[i+1] = w_acc | (w_run & c_in);
        end
        w_grp_g = w_acc;
        w_grp_p = w_run;
    end

    assign s     = w_prop ^ w_c[BLOCK-1:0];
    assign c_out = w_c[BLOCK];
    assign g     = w_grp_g;
    assign p     = w_grp_p;

endmodule
`default_nettype wire

// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pipe_addsub
//  Brief    : Skewed-pipeline carry-lookahead adder/subtractor, valid/ready
//             on both sides. Define CLA_PIPE_OVF_EN to add the ovf output.
//  Revision : 1.0 - initial release
// ============================================================================
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSTG = cla_nstg(WIDTH, BLOCK);

    if (BLOCK < 1) begin : g_bad_block
        $error("cla_pipe_addsub: BLOCK must be at least 1");
    end else if ((WIDTH % BLOCK) != 0) begin : g_bad_width
        $error("cla_pipe_addsub: WIDTH must be a multiple of BLOCK");
    end

    typedef struct packed {
        cla_ctrl_t        ctrl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bx;
    } stage_t;

    // Entry 0 holds the conditioned input beat; entry k+1 holds the result of
    // lookahead group k. Entry NSTG drives the outputs.
    stage_t r_stg [NSTG+1];
    stage_t w_nxt [NSTG+1];

    logic             w_advance;
    logic [WIDTH-1:0] w_bx;
    logic             w_c0;

    assign w_advance = ~r_stg[NSTG].ctrl.valid | out_ready;
    assign in_ready  = w_advance;

    assign w_bx     = sub ? ~b : b;
    assign w_c0     = sub ? 1'b1 : cin;
    assign w_nxt[0] = {in_valid, w_c0, {WIDTH{1'b0}}, a, w_bx};

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        localparam int               c_lsb        = k * BLOCK;
        localparam logic [WIDTH-1:0] c_slice_mask = WIDTH'({BLOCK{1'b1}}) << c_lsb;
        localparam logic [WIDTH-1:0] c_upper_mask = {WIDTH{1'b1}} << (c_lsb + BLOCK);

        logic [BLOCK-1:0] w_s;
        logic             w_co;
        logic             w_gg;
        logic             w_gp;

        cla_group #(
            .BLOCK (BLOCK)
        ) u_group (
            .a     (r_stg[k].a[c_lsb +: BLOCK]),
            .b     (r_stg[k].bx[c_lsb +: BLOCK]),
            .c_in  (r_stg[k].ctrl.carry),
            .s     (w_s),
            .c_out (w_co),
            .g     (w_gg),
            .p     (w_gp)
        );

        // Group G/P exist for wider lookahead trees; this pipeline only
        // needs the slice carry-out.
        logic w_unused_gp;
        assign w_unused_gp = w_gg ^ w_gp;

        // Consumed operand slices are dropped so only upper groups travel on.
        assign w_nxt[k+1] = {r_stg[k].ctrl.valid,
                             w_co,
                             (r_stg[k].sum & ~c_slice_mask) | (WIDTH'(w_s) << c_lsb),
                             r_stg[k].a  & c_upper_mask,
                             r_stg[k].bx & c_upper_mask};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= NSTG; k++) begin
                r_stg[k] <= '0;
            end
        end else if (w_advance) begin
            for (int k = 0; k <= NSTG; k++) begin
                r_stg[k] <= w_nxt[k];
            end
        end
    end

    assign out_valid = r_stg[NSTG].ctrl.valid;
    assign sum       = r_stg[NSTG].sum;
    assign cout      = r_stg[NSTG].ctrl.carry;

`ifdef CLA_PIPE_OVF_EN
    logic r_ovf;
    logic w_c_msb;

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign w_c_msb = w_nxt[NSTG].sum[WIDTH-1] ^ r_stg[NSTG-1].a[WIDTH-1]
                   ^ r_stg[NSTG-1].bx[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            r_ovf <= w_c_msb ^ w_nxt[NSTG].ctrl.carry;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_pipe_addsub
//  Brief    : Self-checking bench for cla_pipe_addsub (WIDTH=16, BLOCK=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_addsub;

    localparam int WIDTH = 16;
    localparam int BLOCK = 4;
    localparam int NSTG  = WIDTH / BLOCK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_PIPE_OVF_EN
    logic             ovf;
`endif

    cla_pipe_addsub #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t             q[$];
    int               n_chk = 0;
    int               n_err = 0;
    int               cyc   = 0;
    bit               lat_chk   = 1'b1;
    bit               was_stall = 1'b0;
    bit               last_acc  = 1'b0;
    bit               last_ready = 1'b1;
    logic [WIDTH-1:0] hold_sum;
    logic             hold_cout;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb,
                                   input logic fcin, input logic fsub, input int acc, input bit lat);
        exp_t   e;
        longint ua;
        longint ub;
        longint r;
        int     sr;
        ua = longint'(fa);
        ub = longint'(fb);
        if (fsub) begin
            r      = ua - ub;
            e.cout = (ua >= ub);
            sr     = int'($signed(fa)) - int'($signed(fb));
        end else begin
            r      = ua + ub + longint'(fcin);
            e.cout = r[WIDTH];
            sr     = int'($signed(fa)) + int'($signed(fb)) + int'(fcin);
        end
        e.sum = r[WIDTH-1:0];
        e.ovf = (sr >= (1 <<< (WIDTH-1))) || (sr < -(1 <<< (WIDTH-1)));
        e.acc = acc;
        e.lat = lat;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: called just after an edge with inputs already driven.
    task automatic cycle();
        exp_t e;
        #1;
        chk("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
        if (was_stall) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_sum", {48'd0, sum}, {48'd0, hold_sum});
            chk("hold_cout", {63'd0, cout}, {63'd0, hold_cout});
        end
        last_acc = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid) begin
                n_chk++;
                assert (q.size() > 0) else begin
                    n_err++;
                    $error("FAIL spurious_out: observed sum=%0h with nothing outstanding, expected no out_valid", sum);
                end
                if (out_ready && q.size() > 0) begin
                    e = q.pop_front();
                    chk("sum", {48'd0, sum}, {48'd0, e.sum});
                    chk("cout", {63'd0, cout}, {63'd0, e.cout});
`ifdef CLA_PIPE_OVF_EN
                    chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
`endif
                    if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(NSTG));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin, sub, cyc + 1, lat_chk));
                last_acc = 1'b1;
            end
        end
        was_stall  = !rst && out_valid && !out_ready;
        hold_sum   = sum;
        hold_cout  = cout;
        last_ready = in_ready;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tcin, input logic tsub);
        int budget;
        in_valid = 1'b1;
        a = ta; b = tb; cin = tcin; sub = tsub;
        budget = 0;
        do begin
            cycle();
            budget++;
        end while (!last_acc && budget < 20);
        if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (q.size() > 0 && budget < 40) begin
            cycle();
            budget++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        repeat (2) cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i;
        int k;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {48'd0, sum}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef CLA_PIPE_OVF_EN
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif

        // Directed single beats: group-boundary carry, full ripple, borrow, signed overflow.
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        drain();
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        drain();
        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        drain();

        // Full-rate stream.
        for (int n = 1; n <= 8; n++) send(WIDTH'(n), WIDTH'(n), 1'b0, 1'b0);
        drain();

        // Same stream with a three-cycle downstream stall.
        lat_chk = 1'b0;
        i = 1;
        k = 0;
        while ((i <= 8 || q.size() > 0) && k < 60) begin
            in_valid  = (i <= 8);
            a = WIDTH'(i); b = WIDTH'(i); cin = 1'b0; sub = 1'b0;
            out_ready = !(k >= 5 && k < 8);
            #1;
            if (!out_ready) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            cycle();
            if (last_acc) i++;
            k++;
        end
        drain();
        lat_chk = 1'b1;

        // Reset with three beats in flight.
        for (int n = 0; n < 3; n++) send(16'h1111 * WIDTH'(n + 1), 16'h0101, 1'b0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (8) cycle();

        // Randomized traffic with random backpressure.
        lat_chk = 1'b0;
        in_valid = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!(in_valid && !last_ready)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a   = WIDTH'($urandom);
                b   = WIDTH'($urandom);
                cin = 1'($urandom);
                sub = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
